// File: rtl/onehot_pkg.sv
// Shared widths and FSM encoding for the one-hot hold decoder and its combinational core.
package onehot_pkg;
    localparam int SEL_W = 3;
    localparam int OUT_W = 1 << SEL_W;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;
endpackage

// File: rtl/onehot_3to8_decode.sv
// Pure combinational binary-to-one-hot decode; usable on its own.
module onehot_3to8_decode
    import onehot_pkg::*;
(
    input  logic [SEL_W-1:0] code,
    output logic [OUT_W-1:0] f_comb
);
    assign f_comb = OUT_W'(1) << code;
endmodule

// File: rtl/onehot_3to8_decoder_hold.sv
// Registered 3-to-8 one-hot decoder: each accepted code is held for HOLD_CYCLES enabled
// cycles, with gapless back-to-back reload when a new code arrives on the last hold cycle.
module onehot_3to8_decoder_hold
    import onehot_pkg::*;
#(
    parameter int HOLD_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] C,
    output logic [OUT_W-1:0] F,
    output logic             busy,
    output logic             done
);
    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [OUT_W-1:0] f_comb, f_n;
    logic             busy_n, done_n;
    logic             last, accept;

    onehot_3to8_decode u_decode (
        .code   (C),
        .f_comb (f_comb)
    );

    // The last hold cycle is also an accept slot, which makes reloads gapless.
    assign last     = (state == ST_HOLD) && (cnt == CNT_ONE);
    assign in_ready = en && ((state == ST_IDLE) || last);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            F     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            F     <= f_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        f_n     = F;
        busy_n  = busy;
        done_n  = 1'b0;
        if (en) begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state_n = ST_HOLD;
                        cnt_n   = CNT_LOAD;
                        f_n     = f_comb;
                        busy_n  = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (cnt > CNT_ONE) begin
                        cnt_n = cnt - CNT_ONE;
                    end else begin
                        done_n = 1'b1;
                        if (accept) begin
                            cnt_n = CNT_LOAD;
                            f_n   = f_comb;
                        end else begin
                            state_n = ST_IDLE;
                            cnt_n   = '0;
                            f_n     = '0;
                            busy_n  = 1'b0;
                        end
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                    f_n     = '0;
                    busy_n  = 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_onehot_3to8_decoder_hold.sv
// Bench for the hold decoder: two instances (hold 4 and hold 1) checked every cycle
// against a code/remaining-cycles reference model, plus directed literal expectations.
module tb_onehot_3to8_decoder_hold;
    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      en, vld, rdy, busy, done;
    logic [1:0][2:0] c;
    logic [1:0][7:0] f;

    int checks = 0;
    int failures = 0;

    int hold[2] = '{4, 1};
    int m_code[2];
    int m_left[2];
    logic [1:0] m_done;

    always #5 clk = ~clk;

    onehot_3to8_decoder_hold #(.HOLD_CYCLES(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en[0]), .in_valid(vld[0]), .in_ready(rdy[0]),
        .C(c[0]), .F(f[0]), .busy(busy[0]), .done(done[0])
    );

    onehot_3to8_decoder_hold #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en[1]), .in_valid(vld[1]), .in_ready(rdy[1]),
        .C(c[1]), .F(f[1]), .busy(busy[1]), .done(done[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // 8-to-3 one-hot encoder used for the round-trip check.
    function automatic int encode(input logic [7:0] v);
        int r = -1;
        for (int i = 0; i < 8; i++) if (v[i]) r = i;
        return r;
    endfunction

    function automatic logic [7:0] model_f(input int d);
        logic [7:0] one = 8'h01;
        return (m_code[d] < 0) ? 8'h00 : (one << m_code[d]);
    endfunction

    task automatic check_outputs();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("F[%0d]", d), 32'(f[d]), 32'(model_f(d)));
            chk($sformatf("busy[%0d]", d), 32'(busy[d]), 32'(m_code[d] >= 0));
            chk($sformatf("done[%0d]", d), 32'(done[d]), 32'(m_done[d]));
            chk($sformatf("onehot0[%0d]", d), 32'($onehot0(f[d])), 32'd1);
            if (f[d] != 8'h00)
                chk($sformatf("roundtrip[%0d]", d), 32'(encode(f[d])), 32'(m_code[d]));
        end
    endtask

    // One clock: check in_ready from current inputs, clock, advance model, check outputs.
    task automatic step();
        logic [1:0] acc;
        logic [1:0] exp_rdy;
        #1;
        for (int d = 0; d < 2; d++) begin
            exp_rdy[d] = en[d] && (m_code[d] < 0 || m_left[d] == 1);
            chk($sformatf("in_ready[%0d]", d), 32'(rdy[d]), 32'(exp_rdy[d]));
            acc[d] = exp_rdy[d] && vld[d];
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            m_done[d] = en[d] && m_code[d] >= 0 && m_left[d] == 1;
            if (en[d]) begin
                if (m_code[d] >= 0) begin
                    m_left[d]--;
                    if (m_left[d] == 0) m_code[d] = -1;
                end
                if (acc[d]) begin
                    m_code[d] = int'(c[d]);
                    m_left[d] = hold[d];
                end
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_code[d] = -1;
            m_left[d] = 0;
        end
        m_done = 2'b00;
    endtask

    initial begin
        int bcnt, dcnt, fhigh;
        logic [7:0] walk[8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

        en = 2'b11; vld = 2'b00; c = '0; rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        chk("reset_in_ready", 32'(rdy), 32'h3);
        rst_n = 1'b1;

        // Sweep every code through the hold-4 instance.
        for (int k = 0; k < 8; k++) begin
            vld[0] = 1'b1; c[0] = 3'(k);
            step();
            chk($sformatf("sweep_F code=%0d", k), 32'(f[0]), 32'(walk[k]));
            vld[0] = 1'b0;
            bcnt = int'(busy[0]); dcnt = int'(done[0]);
            repeat (4) begin
                step();
                bcnt += int'(busy[0]); dcnt += int'(done[0]);
            end
            chk($sformatf("sweep_busy_len code=%0d", k), 32'(bcnt), 32'd4);
            chk($sformatf("sweep_done_cnt code=%0d", k), 32'(dcnt), 32'd1);
        end

        // Back-to-back 3 then 5 with in_valid held: no zero gap.
        vld[0] = 1'b1; c[0] = 3'd3;
        step();
        chk("b2b_first", 32'(f[0]), 32'h08);
        c[0] = 3'd5;
        repeat (3) begin
            step();
            chk("b2b_hold3", 32'(f[0]), 32'h08);
        end
        step();
        chk("b2b_switch_F", 32'(f[0]), 32'h20);
        chk("b2b_switch_done", 32'(done[0]), 32'd1);
        vld[0] = 1'b0;
        repeat (4) step();
        chk("b2b_idle", 32'(f[0]), 32'h00);

        // Freeze with en=0 at cnt=2: total F-high is 4 enabled + 3 frozen cycles.
        vld[0] = 1'b1; c[0] = 3'd2;
        step();
        vld[0] = 1'b0;
        fhigh = int'(f[0] != 0);
        repeat (2) begin step(); fhigh += int'(f[0] != 0); end
        en[0] = 1'b0;
        repeat (3) begin step(); fhigh += int'(f[0] != 0); end
        en[0] = 1'b1;
        repeat (2) begin step(); fhigh += int'(f[0] != 0); end
        chk("freeze_total_high", 32'(fhigh), 32'd7);
        chk("freeze_end_done", 32'(done[0]), 32'd1);

        // Asynchronous reset mid-hold of code 6.
        vld[0] = 1'b1; c[0] = 3'd6;
        step();
        vld[0] = 1'b0;
        step();
        chk("pre_reset_F", 32'(f[0]), 32'h40);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_reset_F", 32'(f[0]), 32'h00);
        chk("async_reset_busy", 32'(busy[0]), 32'd0);
        chk("async_reset_done", 32'(done[0]), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        chk("post_reset_done", 32'(done[0]), 32'd0);
        vld[0] = 1'b1; c[0] = 3'd1;
        step();
        chk("post_reset_F", 32'(f[0]), 32'h02);
        vld[0] = 1'b0;
        repeat (4) step();

        // Hold-1 instance: continuous stream walks one bit per cycle.
        vld[1] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            c[1] = 3'(k);
            step();
            chk($sformatf("walk_F k=%0d", k), 32'(f[1]), 32'(walk[k]));
            chk($sformatf("walk_ready k=%0d", k), 32'(rdy[1]), 32'd1);
        end
        vld[1] = 1'b0;
        step();

        // Randomized traffic on both instances.
        for (int n = 0; n < 600; n++) begin
            for (int d = 0; d < 2; d++) begin
                en[d]  = ($urandom_range(0, 7) != 0);
                vld[d] = ($urandom_range(0, 2) != 0);
                c[d]   = 3'($urandom_range(0, 7));
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
